// File: rtl/centroid_divider.sv
// centroid_divider: snapshots per-cluster colour sums and pixel counts, divides
// each channel sum by its cluster count with one shared bit-serial restoring
// divider, and publishes the new RGB centroids all at once with a change flag.
//
// Handshake: a one-cycle start pulse is accepted only in IDLE; busy is high
// from the accepting edge until the edge that raises the one-cycle done pulse,
// at which point centroids and changed are updated together. start and
// init_valid are ignored whenever the block is not in IDLE.
module centroid_divider #(
    parameter int NumOfClusters = 16,
    parameter int SumWidth      = 26,
    parameter int CountWidth    = 14
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [NumOfClusters*SumWidth-1:0]   red_sum,
    input  logic [NumOfClusters*SumWidth-1:0]   green_sum,
    input  logic [NumOfClusters*SumWidth-1:0]   blue_sum,
    input  logic [NumOfClusters*CountWidth-1:0] co_sum,
    input  logic                                init_valid,
    input  logic [NumOfClusters*24-1:0]         init_centroids,
    output logic [NumOfClusters*24-1:0]         centroids,
    output logic                                busy,
    output logic                                done,
    output logic                                changed,
    output logic [2:0]                          dbg_state
);

    localparam int ClW = (NumOfClusters > 1) ? $clog2(NumOfClusters) : 1;
    localparam int BcW = $clog2(SumWidth + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PREP  = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] STORE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]                          state;
    logic [NumOfClusters*SumWidth-1:0]   red_snap;
    logic [NumOfClusters*SumWidth-1:0]   green_snap;
    logic [NumOfClusters*SumWidth-1:0]   blue_snap;
    logic [NumOfClusters*CountWidth-1:0] co_snap;
    logic [NumOfClusters*24-1:0]         shadow;
    logic [ClW-1:0]                      cl;       // cluster of element e
    logic [1:0]                          ch;       // channel of element e: 0=R 1=G 2=B
    logic [SumWidth-1:0]                 dq;       // dividend shifting out, quotient shifting in
    logic [CountWidth:0]                 rem;
    logic [CountWidth-1:0]               divisor;
    logic [BcW-1:0]                      bitcnt;
    logic                                skip;     // zero count: keep previous byte
    logic                                chg;

    logic [SumWidth-1:0]                 sel_sum;
    logic [CountWidth-1:0]               sel_cnt;
    logic [7:0]                          cur_byte;
    logic [CountWidth:0]                 trial;
    logic                                fits;
    logic [7:0]                          q_byte;
    logic                                last_elem;

    assign dbg_state = state;

    // Select the current element's operands, the published byte it replaces,
    // the next restoring-division step and the saturated quotient byte.
    always_comb begin
        sel_sum  = '0;
        cur_byte = '0;
        case (ch)
            2'd0: begin
                sel_sum  = red_snap[int'(cl)*SumWidth +: SumWidth];
                cur_byte = centroids[int'(cl)*24+16 +: 8];
            end
            2'd1: begin
                sel_sum  = green_snap[int'(cl)*SumWidth +: SumWidth];
                cur_byte = centroids[int'(cl)*24+8 +: 8];
            end
            default: begin
                sel_sum  = blue_snap[int'(cl)*SumWidth +: SumWidth];
                cur_byte = centroids[int'(cl)*24 +: 8];
            end
        endcase
        sel_cnt   = co_snap[int'(cl)*CountWidth +: CountWidth];
        trial     = {rem[CountWidth-1:0], dq[SumWidth-1]};
        fits      = (trial >= {1'b0, divisor});
        q_byte    = (|dq[SumWidth-1:8]) ? 8'hff : dq[7:0];
        last_elem = (cl == ClW'(NumOfClusters - 1)) && (ch == 2'd2);
    end

    // Update FSM: snapshot, per-element divide, shadow store, atomic publish.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            red_snap   <= '0;
            green_snap <= '0;
            blue_snap  <= '0;
            co_snap    <= '0;
            shadow     <= '0;
            centroids  <= '0;
            cl         <= '0;
            ch         <= '0;
            dq         <= '0;
            rem        <= '0;
            divisor    <= '0;
            bitcnt     <= '0;
            skip       <= 1'b0;
            chg        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            changed    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        red_snap   <= red_sum;
                        green_snap <= green_sum;
                        blue_snap  <= blue_sum;
                        co_snap    <= co_sum;
                        cl         <= '0;
                        ch         <= '0;
                        chg        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= PREP;
                    end else if (init_valid) begin
                        centroids <= init_centroids;
                        shadow    <= init_centroids;
                    end
                end
                PREP: begin
                    dq      <= sel_sum;
                    divisor <= sel_cnt;
                    rem     <= '0;
                    bitcnt  <= BcW'(SumWidth);
                    if (sel_cnt == '0) begin
                        skip  <= 1'b1;
                        state <= STORE;
                    end else begin
                        skip  <= 1'b0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem    <= fits ? (trial - {1'b0, divisor}) : trial;
                    dq     <= {dq[SumWidth-2:0], fits};
                    bitcnt <= bitcnt - BcW'(1);
                    if (bitcnt == BcW'(1)) state <= STORE;
                end
                STORE: begin
                    if (!skip) begin
                        case (ch)
                            2'd0:    shadow[int'(cl)*24+16 +: 8] <= q_byte;
                            2'd1:    shadow[int'(cl)*24+8 +: 8]  <= q_byte;
                            default: shadow[int'(cl)*24 +: 8]    <= q_byte;
                        endcase
                        if (q_byte != cur_byte) chg <= 1'b1;
                    end
                    if (last_elem) begin
                        state <= DONE;
                    end else begin
                        if (ch == 2'd2) begin
                            ch <= 2'd0;
                            cl <= cl + ClW'(1);
                        end else begin
                            ch <= ch + 2'd1;
                        end
                        state <= PREP;
                    end
                end
                DONE: begin
                    centroids <= shadow;
                    changed   <= chg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_divider.sv
// Directed bench for centroid_divider: a behavioural division model fills a
// scoreboard at each start; results are popped and compared on done.
module tb_centroid_divider;

    localparam int K  = 16;
    localparam int SW = 26;
    localparam int CW = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [K*SW-1:0]   red_sum = '0;
    logic [K*SW-1:0]   green_sum = '0;
    logic [K*SW-1:0]   blue_sum = '0;
    logic [K*CW-1:0]   co_sum = '0;
    logic              init_valid = 1'b0;
    logic [K*24-1:0]   init_centroids = '0;
    logic [K*24-1:0]   centroids;
    logic              busy;
    logic              done;
    logic              changed;
    logic [2:0]        dbg_state;

    int compared = 0;
    int mismatched = 0;

    logic [23:0] exp_q[$];
    logic        chg_q[$];
    logic [23:0] model_cent[K];

    centroid_divider #(.NumOfClusters(K), .SumWidth(SW), .CountWidth(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
        .co_sum(co_sum), .init_valid(init_valid), .init_centroids(init_centroids),
        .centroids(centroids), .busy(busy), .done(done), .changed(changed),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int r, input int g, input int b, input int c);
        for (int i = 0; i < K; i++) begin
            red_sum[i*SW +: SW]   = SW'(r);
            green_sum[i*SW +: SW] = SW'(g);
            blue_sum[i*SW +: SW]  = SW'(b);
            co_sum[i*CW +: CW]    = CW'(c);
        end
    endtask

    function automatic logic [7:0] model_byte(input longint s, input longint c, input logic [7:0] prev);
        longint q;
        if (c == 0) return prev;
        q = s / c;
        return (q > 255) ? 8'hff : q[7:0];
    endfunction

    // Push expected centroids and change flag from the inputs about to be sampled.
    task automatic push_expected();
        logic [23:0] e;
        logic        any;
        any = 1'b0;
        for (int i = 0; i < K; i++) begin
            e[23:16] = model_byte(longint'(red_sum[i*SW +: SW]),   longint'(co_sum[i*CW +: CW]), model_cent[i][23:16]);
            e[15:8]  = model_byte(longint'(green_sum[i*SW +: SW]), longint'(co_sum[i*CW +: CW]), model_cent[i][15:8]);
            e[7:0]   = model_byte(longint'(blue_sum[i*SW +: SW]),  longint'(co_sum[i*CW +: CW]), model_cent[i][7:0]);
            if (e != model_cent[i]) any = 1'b1;
            exp_q.push_back(e);
        end
        chg_q.push_back(any);
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < K; i++)
            check($sformatf("%s_c%0d", tag, i), 64'(centroids[i*24 +: 24]), 64'(model_cent[i]));
    endtask

    // One update run: start at edge 0, then watch until done (bounded).
    task automatic run(input string tag, input int exp_lat, input int abort_edge, input int inject_edge);
        int n;
        int bad_busy;
        bit seen;
        logic [23:0] e;
        logic c;
        push_expected();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        n = 0; bad_busy = 0; seen = 0;
        while (!seen && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (abort_edge != 0 && n == abort_edge) begin
                reset = 1'b0;
                #1;
                check({tag, "_abort_cent"}, 64'(|centroids), 64'd0);
                check({tag, "_abort_busy"}, 64'(busy), 64'd0);
                check({tag, "_abort_chg"},  64'(changed), 64'd0);
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk); #1;
                    if (done) seen = 1;
                end
                check({tag, "_abort_nodone"}, 64'(seen), 64'd0);
                exp_q.delete();
                chg_q.delete();
                for (int i = 0; i < K; i++) model_cent[i] = '0;
                return;
            end
            if (inject_edge != 0 && n == inject_edge) begin
                start = 1'b1;
                init_valid = 1'b1;
                init_centroids = '1;
                set_all(999, 999, 999, 1);
            end
            if (inject_edge != 0 && n == inject_edge + 1) begin
                start = 1'b0;
                init_valid = 1'b0;
                check_model({tag, "_midrun"});
            end
            if (done) seen = 1;
            else if (busy !== 1'b1) bad_busy++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_high"}, 64'(bad_busy), 64'd0);
        check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        for (int i = 0; i < K; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_cent%0d", tag, i), 64'(centroids[i*24 +: 24]), 64'(e));
            model_cent[i] = e;
        end
        c = chg_q.pop_front();
        check({tag, "_changed"}, 64'(changed), 64'(c));
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < K; i++) model_cent[i] = '0;
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rst_cent", 64'(|centroids), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_chg",  64'(changed), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // Basic: 4/8/12 over count 4 -> {1,2,3}
        set_all(4, 8, 12, 4);
        run("basic", 1345, 0, 0);
        // Identical repeat -> no change
        run("repeat", 1345, 0, 0);

        // Arithmetic boundaries
        red_sum[0*SW +: SW]   = SW'(10);
        green_sum[0*SW +: SW] = SW'(1020);
        blue_sum[0*SW +: SW]  = SW'(1023);
        red_sum[1*SW +: SW]   = SW'(2000);
        green_sum[1*SW +: SW] = SW'(2000);
        blue_sum[1*SW +: SW]  = SW'(2000);
        co_sum[1*CW +: CW]    = CW'(1);
        red_sum[2*SW +: SW]   = SW'(67108863);
        green_sum[2*SW +: SW] = SW'(67108863);
        blue_sum[2*SW +: SW]  = SW'(67108863);
        co_sum[2*CW +: CW]    = CW'(16383);
        run("bound", 1345, 0, 0);

        // Init load, then zero-count cluster keeps its loaded centroid
        for (int i = 0; i < K; i++)
            init_centroids[i*24 +: 24] = (i == 5) ? 24'h102030 : {8'(i), 8'(i), 8'(i)};
        @(negedge clk) init_valid = 1'b1;
        @(posedge clk); #1 init_valid = 1'b0;
        for (int i = 0; i < K; i++) model_cent[i] = init_centroids[i*24 +: 24];
        check_model("init");
        set_all(4, 8, 12, 4);
        co_sum[5*CW +: CW] = '0;
        run("zerocnt", 1267, 0, 0);

        // Reset mid-run, then release and restart
        set_all(4, 8, 12, 4);
        run("abort", 0, 500, 0);
        @(negedge clk) reset = 1'b1;
        run("restart", 1345, 0, 0);

        // start/init_valid pulses while busy are ignored; snapshot isolates inputs
        set_all(40, 80, 120, 4);
        run("ignore", 1345, 0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
